// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase and light encodings for the intersection controller
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10,
        PH_FLASH   = 2'b11
    } phase_t;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

endpackage

// File: rtl/tl_next_dir.sv
// tl_next_dir: round-robin pick of the next approach with demand after the current one
module tl_next_dir #(
    parameter int NUM_DIR = 4,
    parameter int DIR_W   = 2
) (
    input  logic [NUM_DIR-1:0] veh_req,
    input  logic [DIR_W-1:0]   active_dir,
    output logic [DIR_W-1:0]   next_dir
);

    logic found;

    // scan forward from active_dir+1; the active approach itself is checked last
    always_comb begin
        next_dir = (int'(active_dir) == NUM_DIR - 1) ? '0 : active_dir + 1'b1;
        found = 1'b0;
        for (int k = 1; k <= NUM_DIR; k++) begin
            if (!found && veh_req[(int'(active_dir) + k) % NUM_DIR]) begin
                next_dir = DIR_W'((int'(active_dir) + k) % NUM_DIR);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n: N-approach round-robin signal controller with rest-in-green and flash mode
module traffic_light_ctrl_n
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int FLASH_CYC  = 4,
    localparam int DIR_W     = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_DIR-1:0]     veh_req,
    input  logic                   flash_en,
    output logic [3*NUM_DIR-1:0]   light,
    output logic [1:0]             phase,
    output logic [DIR_W-1:0]       active_dir
);

    localparam int MAX_GY = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
    localparam int MAX_AF = (ALLRED_CYC > FLASH_CYC) ? ALLRED_CYC : FLASH_CYC;
    localparam int MAX_D  = (MAX_GY > MAX_AF) ? MAX_GY : MAX_AF;
    localparam int TW     = $clog2(MAX_D) + 1;

    phase_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [DIR_W-1:0]     dir_q, dir_d, next_dir;
    logic                 blink_q, blink_d;
    logic [3*NUM_DIR-1:0] light_q, light_d;
    logic                 other_req;

    tl_next_dir #(.NUM_DIR(NUM_DIR), .DIR_W(DIR_W)) u_next_dir (
        .veh_req    (veh_req),
        .active_dir (dir_q),
        .next_dir   (next_dir)
    );

    assign other_req  = |(veh_req & ~(NUM_DIR'(1) << dir_q));
    assign phase      = state_q;
    assign active_dir = dir_q;
    assign light      = light_q;

    // phase sequencing; timer saturates at 0 so a resting green holds there.
    // With no demand anywhere green is not held, giving fixed-time rotation.
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == '0) ? '0 : timer_q - 1'b1;
        dir_d   = dir_q;
        blink_d = blink_q;
        case (state_q)
            PH_ALL_RED: if (timer_q == '0) begin
                state_d = flash_en ? PH_FLASH : PH_GREEN;
                timer_d = flash_en ? TW'(FLASH_CYC - 1) : TW'(GREEN_CYC - 1);
                dir_d   = flash_en ? dir_q : next_dir;
                blink_d = 1'b1;
            end
            PH_GREEN: if (flash_en || (timer_q == '0 && (other_req || !(|veh_req)))) begin
                state_d = PH_YELLOW;
                timer_d = TW'(YELLOW_CYC - 1);
            end
            PH_YELLOW: if (timer_q == '0) begin
                state_d = flash_en ? PH_FLASH : PH_ALL_RED;
                timer_d = flash_en ? TW'(FLASH_CYC - 1) : TW'(ALLRED_CYC - 1);
                blink_d = 1'b1;
            end
            default: if (!flash_en) begin
                state_d = PH_ALL_RED;
                timer_d = TW'(ALLRED_CYC - 1);
            end else if (timer_q == '0) begin
                blink_d = ~blink_q;
                timer_d = TW'(FLASH_CYC - 1);
            end
        endcase
    end

    // decode lights from the next state so they register alongside it
    always_comb begin
        light_d = '0;
        for (int i = 0; i < NUM_DIR; i++)
            light_d[3*i +: 3] = (state_d == PH_FLASH) ? (blink_d ? LT_YEL : LT_OFF) :
                                (DIR_W'(i) == dir_d && state_d == PH_GREEN)  ? LT_GRN :
                                (DIR_W'(i) == dir_d && state_d == PH_YELLOW) ? LT_YEL : LT_RED;
    end

    // state, timer, blink and light registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PH_ALL_RED;
            timer_q <= TW'(ALLRED_CYC - 1);
            dir_q   <= DIR_W'(NUM_DIR - 1);
            blink_q <= 1'b1;
            light_q <= {NUM_DIR{LT_RED}};
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            blink_q <= blink_d;
            light_q <= light_d;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// tb_traffic_light_ctrl_n: scoreboard bench against a cycle model of the controller
module tb_traffic_light_ctrl_n;

    localparam int N = 4, GRN = 8, YEL = 3, AR = 2, FL = 4;

    typedef struct packed {
        logic [11:0] l;
        logic [1:0]  p;
        logic [1:0]  d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  veh_req = 4'h0;
    logic        flash_en = 1'b0;
    logic [11:0] light;
    logic [1:0]  phase;
    logic [1:0]  active_dir;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    int m_ph = 2, m_dir = 3, m_el = 0;
    logic m_blink = 1'b1;
    int ar_run = 0, y_run = 0;
    logic [1:0] prev_ph = 2'b10;
    logic prev_rst = 1'b0;

    traffic_light_ctrl_n #(
        .NUM_DIR(N), .GREEN_CYC(GRN), .YELLOW_CYC(YEL), .ALLRED_CYC(AR), .FLASH_CYC(FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .veh_req    (veh_req),
        .flash_en   (flash_en),
        .light      (light),
        .phase      (phase),
        .active_dir (active_dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int cur, input logic [3:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(cur + k) % N]) return (cur + k) % N;
        return (cur + 1) % N;
    endfunction

    task automatic go(input int p);
        m_ph = p;
        m_el = 0;
        if (p == 3) m_blink = 1'b1;
    endtask

    task automatic model_step();
        logic others;
        if (!rst) begin
            m_ph = 2; m_dir = 3; m_el = 0; m_blink = 1'b1;
            return;
        end
        others = |(veh_req & ~(4'b0001 << m_dir));
        case (m_ph)
            0: if (flash_en || (m_el + 1 >= GRN && (others || veh_req == 4'h0))) go(1); else m_el++;
            1: if (m_el + 1 >= YEL) go(flash_en ? 3 : 2); else m_el++;
            2: if (m_el + 1 >= AR) begin
                   if (flash_en) go(3);
                   else begin m_dir = pick(m_dir, veh_req); go(0); end
               end else m_el++;
            default: if (!flash_en) go(2);
                     else if (m_el + 1 >= FL) begin m_blink = !m_blink; m_el = 0; end
                     else m_el++;
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.p = 2'(m_ph);
        e.d = 2'(m_dir);
        for (int i = 0; i < N; i++)
            e.l[3*i +: 3] = (m_ph == 3) ? (m_blink ? 3'b010 : 3'b000) :
                            (i == m_dir && m_ph == 0) ? 3'b001 :
                            (i == m_dir && m_ph == 1) ? 3'b010 : 3'b100;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        int go_cnt;
        model_step();
        sb.push_back(model_out());
        prev_rst = rst;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("light", 32'(light), 32'(e.l));
        chk("phase", 32'(phase), 32'(e.p));
        chk("dir", 32'(active_dir), 32'(e.d));
        if (phase != 2'b11) begin
            go_cnt = 0;
            for (int i = 0; i < N; i++) if (light[3*i +: 3] != 3'b100) go_cnt++;
            chk("one_go", 32'(go_cnt <= 1), 32'd1);
        end
        if (phase == 2'b00 && prev_ph != 2'b00) chk("ar_before_g", 32'(ar_run >= AR), 32'd1);
        if (prev_ph == 2'b01 && phase != 2'b01 && prev_rst) chk("y_len", 32'(y_run >= YEL), 32'd1);
        ar_run = (phase == 2'b10) ? ar_run + 1 : 0;
        y_run  = (phase == 2'b01) ? y_run + 1 : 0;
        prev_ph = phase;
    endtask

    task automatic run_until(input int p);
        for (int n = 0; n < 100 && m_ph != p; n++) tick();
        chk("reach_phase", 32'(phase), 32'(p));
    endtask

    initial begin
        veh_req = 4'hF; rst = 1'b0;
        tick();
        chk("rst_light", 32'(light), 32'h924);
        rst = 1'b1;
        repeat (60) tick();

        rst = 1'b0; veh_req = 4'b0100;
        tick();
        rst = 1'b1;
        repeat (40) tick();
        chk("rest_phase", 32'(phase), 32'd0);
        chk("rest_dir", 32'(active_dir), 32'd2);
        veh_req = 4'b0101;
        tick();
        chk("leave_rest", 32'(phase), 32'd1);
        repeat (10) tick();
        chk("dir0_green", 32'(light), 32'h921);

        rst = 1'b0; veh_req = 4'h0;
        tick();
        rst = 1'b1;
        repeat (60) tick();

        veh_req = 4'hF;
        run_until(0);
        repeat (3) tick();
        flash_en = 1'b1;
        tick();
        chk("flash_yel", 32'(phase), 32'd1);
        repeat (30) tick();
        flash_en = 1'b0;
        repeat (20) tick();

        run_until(1);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_phase", 32'(phase), 32'd2);
        chk("mid_rst_dir", 32'(active_dir), 32'd3);
        rst = 1'b1;
        repeat (30) tick();

        repeat (400) begin
            if ($urandom_range(0, 5) == 0) veh_req = 4'($urandom);
            if ($urandom_range(0, 40) == 0) flash_en = ~flash_en;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
